// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath bundle between the ALU issue controller and its neighbours:
// instruction source, host register-file port, the registered ALU and the result consumer.
interface alu_issue_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic             instr_valid;
  logic [7:0]       instr;
  logic             instr_ready;
  logic             host_we;
  logic [1:0]       host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;
  logic [1:0]       alu_cnt;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_out;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_rd;
  logic             res_ready;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  instr_valid, instr, host_we, host_addr, host_wdata, alu_out, res_ready,
    output instr_ready, host_rdata, alu_cnt, alu_in0, alu_in1, res_valid, res_data, res_rd,
           busy, op_count
  );

  modport slave (
    output instr_valid, instr, host_we, host_addr, host_wdata, alu_out, res_ready,
    input  instr_ready, host_rdata, alu_cnt, alu_in0, alu_in1, res_valid, res_data, res_rd,
           busy, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for a registered 2-bit-opcode ALU: reads a 4-entry register file,
// drives the ALU for one cycle, then holds the result until downstream takes it and writes it back.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  alu_issue_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StIssue = 2'd1, StWb = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [WIDTH-1:0] rf_d [4];
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [1:0]       rd_q, rd_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             ready;

  // Gated by rst so the source never sees ready while the block is held in reset.
  assign ready = (state_q == StIdle) && rst;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    cnt_d       = cnt_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rd_d        = rd_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;

    // Host write first so a same-edge write-back to the same entry overrides it.
    if (bus.host_we) begin
      rf_d[bus.host_addr] = bus.host_wdata;
    end

    case (state_q)
      StIdle: begin
        if (bus.instr_valid && ready) begin
          cnt_d   = bus.instr[7:6];
          rd_d    = bus.instr[5:4];
          in0_d   = rf_q[bus.instr[3:2]];
          in1_d   = rf_q[bus.instr[1:0]];
          state_d = StIssue;
        end
      end
      StIssue: begin
        res_valid_d = 1'b1;
        state_d     = StWb;
      end
      StWb: begin
        if (bus.res_ready) begin
          rf_d[rd_q]  = bus.alu_out;
          op_count_d  = op_count_q + CNT_W'(1);
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rf_q        <= '{default: '0};
      cnt_q       <= 2'b00;
      in0_q       <= '0;
      in1_q       <= '0;
      rd_q        <= 2'b00;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      cnt_q       <= cnt_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.host_rdata  = rf_q[bus.host_addr];
  assign bus.alu_cnt     = cnt_q;
  assign bus.alu_in0     = in0_q;
  assign bus.alu_in1     = in1_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_valid_q ? bus.alu_out : '0;
  assign bus.res_rd      = rd_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.op_count    = op_count_q;

endmodule
